// File: rtl/lock_reg_arbiter.sv
// lock_reg_arbiter: round-robin write arbiter for a bank of lockable
// config registers. Owns register contents and sticky per-register locks.
//
// Ports:
//   Clk, resetn          clock (rising), async active-low reset
//   req/req_trusted/     per-requester request, trust and lock-after-write
//   req_lock
//   req_addr, req_data   packed per-requester target and write data
//   debug_mode           global debug enable, sampled at commit
//   gnt                  one-hot grant, held through GRANT and RESP
//   done, err            one-cycle commit / reject pulse in RESP
//   reg_q, lock_q        register contents and lock status
//
// Build option: define LOCK_REG_DEBUG_OVERRIDE_EN to let trusted
// requesters write locked registers while debug_mode is high.
module lock_reg_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 4,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       Clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_trusted,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       debug_mode,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       done,
  output logic                       err,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        lock_q
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RESP
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    win_q;
  logic [IDX_W-1:0]    win_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                trust_q;
  logic                lockreq_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic in_range;
  logic locked;
  logic permit;
  logic reject;

  // Scan from the highest offset down so the
  // lowest offset from rr_ptr wins.
  always_comb begin
    int unsigned idx;
    win_d = rr_ptr_q;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req[idx]) win_d = IDX_W'(idx);
    end
  end

  always_comb begin
    in_range = int'(addr_q) < NUM_REGS;
    locked   = in_range ? lock_q[addr_q] : 1'b0;
`ifdef LOCK_REG_DEBUG_OVERRIDE_EN
    permit   = ~locked | (debug_mode & trust_q);
`else
    permit   = ~locked;
`endif
    reject   = ~in_range | ~permit
             | (lockreq_q & ~trust_q);
  end

`ifndef LOCK_REG_DEBUG_OVERRIDE_EN
  logic unused_debug;
  assign unused_debug = debug_mode;
`endif

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      trust_q   <= 1'b0;
      lockreq_q <= 1'b0;
      gnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      lock_q    <= '0;
      for (int k = 0; k < NUM_REGS; k++)
        regs_q[k] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            win_q     <= win_d;
            addr_q    <= req_addr[win_d*ADDR_W +: ADDR_W];
            data_q    <= req_data[win_d*DATA_W +: DATA_W];
            trust_q   <= req_trusted[win_d];
            lockreq_q <= req_lock[win_d];
            gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (reject) begin
            err <= 1'b1;
          end else begin
            done <= 1'b1;
            regs_q[addr_q] <= data_q;
            // An override write never clears a lock.
            if (lockreq_q) lock_q[addr_q] <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          done     <= 1'b0;
          err      <= 1'b0;
          gnt      <= '0;
          rr_ptr_q <= (int'(win_q) == NUM_REQ - 1)
                    ? '0 : win_q + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_q[k*DATA_W +: DATA_W] = regs_q[k];
  end

endmodule

// File: tb/tb_lock_reg_arbiter.sv
// Scoreboard bench for lock_reg_arbiter: directed transactions push
// expected responses; a monitor pops and checks on every done/err.
module tb_lock_reg_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int NG = 4;
  localparam int AW = 2;

  typedef struct {
    logic [NR-1:0] gnt;
    logic          done;
    logic          err;
    int            addr;
    logic [DW-1:0] data;
    logic [NG-1:0] lock;
  } exp_t;

  logic             Clk;
  logic             resetn;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_trusted;
  logic [NR-1:0]    req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic             debug_mode;
  logic [NR-1:0]    gnt;
  logic             done;
  logic             err;
  logic [NG*DW-1:0] reg_q;
  logic [NG-1:0]    lock_q;

  int   checks;
  int   failures;
  exp_t sb[$];

  lock_reg_arbiter dut (
    .Clk         (Clk),
    .resetn      (resetn),
    .req         (req),
    .req_trusted (req_trusted),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .debug_mode  (debug_mode),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .reg_q       (reg_q),
    .lock_q      (lock_q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    logic [NG*DW-1:0] v;
    v = reg_q;
    return v[k*DW +: DW];
  endfunction

  // Monitor: every done/err pulse must match the oldest expectation.
  always @(negedge Clk) begin
    if (resetn && (done || err)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: done=%0b err=%0b",
                 done, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_gnt",  32'(gnt),  32'(e.gnt));
        check("mon_done", 32'(done), 32'(e.done));
        check("mon_err",  32'(err),  32'(e.err));
        check("mon_reg",  32'(rd(e.addr)), 32'(e.data));
        check("mon_lock", 32'(lock_q), 32'(e.lock));
      end
    end
  end

  task automatic push(input logic [NR-1:0] g,
                      input logic ok,
                      input int a,
                      input logic [DW-1:0] d,
                      input logic [NG-1:0] l);
    exp_t e;
    e.gnt  = g;
    e.done = ok;
    e.err  = ~ok;
    e.addr = a;
    e.data = d;
    e.lock = l;
    sb.push_back(e);
  endtask

  task automatic issue(input int idx,
                       input logic tr,
                       input logic lk,
                       input int a,
                       input logic [DW-1:0] d,
                       input logic dbg);
    bit seen;
    @(negedge Clk);
    req_trusted[idx]        = tr;
    req_lock[idx]           = lk;
    req_addr[idx*AW +: AW]  = AW'(a);
    req_data[idx*DW +: DW]  = d;
    debug_mode              = dbg;
    req[idx]                = 1'b1;
    @(posedge Clk);
    #1;
    check("gnt_t1", 32'(gnt), 32'(1 << idx));
    @(negedge Clk);
    req = '0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clk);
      if (done || err) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL timeout: no done/err for req %0d", idx);
    end
    @(negedge Clk);
  endtask

  initial begin
    int cyc;
    int cnt;
    int tstamp[5];
    checks      = 0;
    failures    = 0;
    resetn      = 1'b0;
    req         = '0;
    req_trusted = '0;
    req_lock    = '0;
    req_addr    = '0;
    req_data    = '0;
    debug_mode  = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_gnt",  32'(gnt),    32'h0);
    check("rst_done", 32'(done),   32'h0);
    check("rst_err",  32'(err),    32'h0);
    check("rst_reg",  32'(reg_q),  32'h0);
    check("rst_lock", 32'(lock_q), 32'h0);
    resetn = 1'b1;
    @(negedge Clk);

    push(4'b0001, 1'b1, 1, 16'hA5A5, 4'b0000);
    issue(0, 1'b0, 1'b0, 1, 16'hA5A5, 1'b0);

    push(4'b0100, 1'b1, 0, 16'h1234, 4'b0001);
    issue(2, 1'b1, 1'b1, 0, 16'h1234, 1'b0);

    push(4'b0010, 1'b0, 0, 16'h1234, 4'b0001);
    issue(1, 1'b0, 1'b0, 0, 16'hFFFF, 1'b0);

`ifdef LOCK_REG_DEBUG_OVERRIDE_EN
    push(4'b1000, 1'b1, 0, 16'hBEEF, 4'b0001);
`else
    push(4'b1000, 1'b0, 0, 16'h1234, 4'b0001);
`endif
    issue(3, 1'b1, 1'b0, 0, 16'hBEEF, 1'b1);

    // Trusted but debug off: locked register stays protected.
`ifdef LOCK_REG_DEBUG_OVERRIDE_EN
    push(4'b1000, 1'b0, 0, 16'hBEEF, 4'b0001);
`else
    push(4'b1000, 1'b0, 0, 16'h1234, 4'b0001);
`endif
    issue(3, 1'b1, 1'b0, 0, 16'h4444, 1'b0);

    push(4'b0010, 1'b0, 2, 16'h0000, 4'b0001);
    issue(1, 1'b0, 1'b1, 2, 16'h7777, 1'b0);

    check("reg1_keep", 32'(rd(1)), 32'hA5A5);

    // Reset during GRANT discards the pending write.
    @(negedge Clk);
    req_trusted = '0;
    req_lock    = '0;
    debug_mode  = 1'b0;
    req_addr[3*AW +: AW] = 2'd3;
    req_data[3*DW +: DW] = 16'h5555;
    req[3] = 1'b1;
    @(posedge Clk);
    #2;
    check("mid_gnt", 32'(gnt), 32'b1000);
    resetn = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    @(negedge Clk);
    req = '0;
    @(negedge Clk);
    resetn = 1'b1;
    repeat (4) @(negedge Clk);
    check("mid_reg3", 32'(rd(3)), 32'h0);
    check("mid_reg0", 32'(rd(0)), 32'h0);
    check("mid_lock", 32'(lock_q), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    check("mid_err",  32'(err),  32'h0);

    // All requesters held high: strict rotation, 3 cycles apart.
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = 2'd3;
      req_data[i*DW +: DW] = DW'(16'h1000 + i);
    end
    for (int k = 0; k < 5; k++)
      push(4'(1 << (k % 4)), 1'b1, 3,
           DW'(16'h1000 + (k % 4)), 4'b0000);
    req = '1;
    cyc = 0;
    cnt = 0;
    while (cnt < 5 && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (done || err) begin
        tstamp[cnt] = cyc;
        cnt++;
        if (cnt == 5) req = '0;
      end
    end
    req = '0;
    check("rr_count", 32'(cnt), 32'd5);
    for (int k = 1; k < 5; k++)
      if (k < cnt)
        check("rr_period", 32'(tstamp[k] - tstamp[k-1]), 32'd3);
    repeat (4) @(negedge Clk);
    check("rr_idle_gnt", 32'(gnt), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lock_reg_arbiter.md
# lock_reg_arbiter

Arbitrated write controller for a bank of lockable configuration registers. Up to NUM_REQ requesters compete for write access through a round-robin arbiter. Each register carries a sticky lock bit that, once set, blocks further writes until reset, except for trusted writes issued in debug mode. The block sits between the configuration masters and the lockable register file, and owns both the register contents and the lock state.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 16: register width
- NUM_REGS, 4: registers in the bank; ADDR_W = clog2(NUM_REGS), minimum 1

- Clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester write request, level
- req_trusted  in  NUM_REQ  requester is trusted
- req_lock  in  NUM_REQ  set the target register's lock after the write
- req_addr  in  NUM_REQ*ADDR_W  target register; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  write data; requester i at [i*DATA_W +: DATA_W]
- debug_mode  in  1  global debug enable
- gnt  out  NUM_REQ  one-hot grant, registered
- done  out  1  one-cycle pulse: granted transaction committed
- err  out  1  one-cycle pulse: granted transaction rejected, no state change
- reg_q  out  NUM_REGS*DATA_W  register contents; register k at [k*DATA_W +: DATA_W]
- lock_q  out  NUM_REGS  per-register lock status

## Operation
- FSM states: IDLE, GRANT, RESP.
  - IDLE: if any req bit is set, pick the winner round-robin starting at rr_ptr. Latch the winner's addr, data, trusted and lock fields, and its index. Go to GRANT. gnt is 0 in IDLE.
  - GRANT: gnt[winner] = 1. Evaluate the latched request and commit or reject at the closing edge. Go to RESP.
  - RESP: gnt[winner] stays 1. Exactly one of done or err is 1. Set rr_ptr = (winner+1) mod NUM_REQ. Go to IDLE.
- Commit rule, with L = lock_q[addr]:
  - Write is permitted if ~L.
  - A locked register is also writable if debug_mode & trusted (see Configuration).
  - A permitted write loads reg_q[addr] with data.
  - If lock is set, the request also sets lock_q[addr] = 1.
- Reject (err) cases:
  - Write not permitted.
  - req_lock from an untrusted requester, even if the register is unlocked. Neither data nor lock changes.
- Locks are sticky. They clear only on resetn. A debug override write never clears a lock.
- Requests are sampled only in IDLE. req changes during GRANT or RESP are ignored.
- A requester keeping req high re-enters arbitration on the next IDLE. It does not get priority over others.
- debug_mode is sampled in GRANT, at the same edge as the commit.
- Address is always in range when NUM_REGS is a power of 2. Otherwise, addr >= NUM_REGS gives err.

## Timing
- Reset values:
  - gnt = 0, done = 0, err = 0.
  - reg_q = 0, lock_q = 0.
  - rr_ptr = 0, state = IDLE.
- Request with req high at edge t (state IDLE):
  - gnt is valid in cycle t+1.
  - reg_q and lock_q update at edge t+2.
  - done/err is high in cycle t+2.
  - State returns to IDLE at t+3.
- Throughput: one transaction per 3 cycles. There is no back-to-back commit.
- Reset asserted mid-transaction:
  - Returns to IDLE immediately.
  - A pending write is discarded if resetn falls before its commit edge.
  - All outputs take their reset values.
- Simultaneous requests: the lowest index at or above rr_ptr wins, wrapping around.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- LOCK_REG_DEBUG_OVERRIDE_EN
  - Defined: trusted writes with debug_mode = 1 may update locked registers, leaving lock_q unchanged.
  - Undefined: locked registers are never writable. debug_mode is unused, and any write to a locked register returns err.

## Test plan
- Reset, then requester 0 writes 0xA5A5 to reg 1, untrusted, no lock: gnt = 0001 at t+1, done at t+2, reg 1 = 0xA5A5, lock_q = 0000.
- Trusted requester 2 writes 0x1234 to reg 0 with req_lock; then requester 1 writes 0xFFFF to reg 0: first gives done and lock_q[0] = 1; second gives err and reg 0 stays 0x1234.
- With the macro defined, debug_mode = 1, trusted requester 3 writes 0xBEEF to locked reg 0: done, reg 0 = 0xBEEF, lock_q[0] stays 1. Without the macro: err, reg 0 = 0x1234.
- Untrusted requester 1 sets req_lock on unlocked reg 2: err, reg 2 and lock_q[2] unchanged.
- All four requesters held high continuously: grant order 0,1,2,3,0, one gnt every 3 cycles.
- resetn pulsed low during GRANT of a write of 0x5555 to reg 3: reg 3 = 0, lock_q = 0, no done/err pulse, FSM in IDLE after release.
